// File: rtl/aes_key_schedule_gen.sv
// AES-128/256 round-key generator: streams FIPS-197 round keys forward (0..Nr) or reverse (Nr..0),
// one key per ready/valid transfer, expanding the stored cipher key one step per clock.
module aes_key_schedule_gen #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                restart,
    input  logic                dir,
    input  logic                rk_ready,
    output logic                rk_valid,
    output logic [127:0]        round_key,
    output logic [3:0]          round_idx,
    output logic                rk_last,
    output logic                busy
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NH = NK / 4;
    localparam int P  = NR - (NH - 1);
    localparam bit WIDE = (KEY_BITS == 256);
    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] P_M1  = 4'(P - 1);
    localparam logic [3:0] NH_M1 = 4'(NH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PRECOMP = 2'd1, EMIT = 2'd2} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = a;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rcon[n] = x^(n-1), generated from the step index rather than looked up
    function automatic logic [31:0] rcon_word(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 2; k <= 14; k++) begin
            if (4'(k) <= n) r = xtime(r);
        end
        return {r, 24'h000000};
    endfunction

    state_t              state_r;
    logic [KEY_BITS-1:0] key_r;
    logic [255:0]        win_r;
    logic [3:0]          pos_r;
    logic                dir_r;

    logic [KEY_BITS-1:0] load_key_s;
    logic [255:0]        load_win_s;
    logic [255:0]        fwd_win_s;
    logic [255:0]        inv_win_s;
    logic [3:0]          next_idx_s;
    logic [3:0]          last_idx_s;
    logic                held_s;
    logic [127:0]        cur_key_s;
    logic [127:0]        next_key_s;

    // Key source for a new run: a fresh key_in wins over the stored key
    always_comb begin
        if (key_load) begin
            load_key_s = key_in;
        end else begin
            load_key_s = key_r;
        end
    end

    generate
        if (KEY_BITS == 128) begin : g_aes128
            logic [31:0] w0_s, w1_s, w2_s, w3_s, n0_s, n1_s, n2_s, n3_s, p0_s, p1_s, p2_s, p3_s;

            assign load_win_s = {load_key_s, load_key_s};

            // Window low half is rk_pos; step one round key forward or back
            always_comb begin
                {w0_s, w1_s, w2_s, w3_s} = win_r[127:0];
                n0_s = w0_s ^ sub_word(rot_word(w3_s)) ^ rcon_word(pos_r + 4'd1);
                n1_s = w1_s ^ n0_s;
                n2_s = w2_s ^ n1_s;
                n3_s = w3_s ^ n2_s;
                p3_s = w3_s ^ w2_s;
                p2_s = w2_s ^ w1_s;
                p1_s = w1_s ^ w0_s;
                p0_s = w0_s ^ sub_word(rot_word(p3_s)) ^ rcon_word(pos_r);
                fwd_win_s = {win_r[127:0], n0_s, n1_s, n2_s, n3_s};
                inv_win_s = {win_r[255:128], p0_s, p1_s, p2_s, p3_s};
            end
        end else if (KEY_BITS == 256) begin : g_aes256
            logic [31:0] a0_s, a1_s, a2_s, a3_s, b0_s, b1_s, b2_s, b3_s, tf_s, ti_s;

            assign load_win_s = load_key_s;

            // Window is (rk_pos, rk_pos+1); even positions use the g function going forward
            always_comb begin
                {a0_s, a1_s, a2_s, a3_s, b0_s, b1_s, b2_s, b3_s} = win_r;
                if (pos_r[0]) begin
                    tf_s = sub_word(b3_s);
                    ti_s = sub_word(rot_word(a3_s)) ^ rcon_word({1'b0, pos_r[3:1]} + 4'd1);
                end else begin
                    tf_s = sub_word(rot_word(b3_s)) ^ rcon_word({1'b0, pos_r[3:1]} + 4'd1);
                    ti_s = sub_word(a3_s);
                end
                fwd_win_s = {b0_s, b1_s, b2_s, b3_s, a0_s ^ tf_s, a0_s ^ tf_s ^ a1_s,
                             a0_s ^ tf_s ^ a1_s ^ a2_s, a0_s ^ tf_s ^ a1_s ^ a2_s ^ a3_s};
                inv_win_s = {b0_s ^ ti_s, b1_s ^ b0_s, b2_s ^ b1_s, b3_s ^ b2_s,
                             a0_s, a1_s, a2_s, a3_s};
            end
        end else begin : g_bad_key_bits
            $error("aes_key_schedule_gen: KEY_BITS must be 128 or 256");
        end
    endgenerate

    // Next index and key for a transfer; step the window only if that key is not already held
    always_comb begin
        if (dir_r) begin
            next_idx_s = round_idx - 4'd1;
            last_idx_s = 4'd0;
            held_s     = (next_idx_s >= pos_r);
        end else begin
            next_idx_s = round_idx + 4'd1;
            last_idx_s = NR_L;
            held_s     = (next_idx_s <= pos_r + NH_M1);
        end
        if (WIDE && (round_idx == pos_r)) begin
            cur_key_s = win_r[255:128];
        end else begin
            cur_key_s = win_r[127:0];
        end
        if (held_s) begin
            if (WIDE && (next_idx_s == pos_r)) begin
                next_key_s = win_r[255:128];
            end else begin
                next_key_s = win_r[127:0];
            end
        end else if (dir_r) begin
            if (WIDE) begin
                next_key_s = inv_win_s[255:128];
            end else begin
                next_key_s = inv_win_s[127:0];
            end
        end else begin
            next_key_s = fwd_win_s[127:0];
        end
    end

    // Run control FSM with registered outputs; a new load/restart aborts any run in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            key_r     <= '0;
            win_r     <= 256'h0;
            pos_r     <= 4'd0;
            dir_r     <= 1'b0;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            busy      <= 1'b0;
            round_key <= 128'h0;
            round_idx <= 4'd0;
        end else if (key_load || restart) begin
            if (key_load) key_r <= key_in;
            win_r     <= load_win_s;
            pos_r     <= 4'd0;
            dir_r     <= dir;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            busy      <= 1'b1;
            round_idx <= dir ? NR_L : 4'd0;
            state_r   <= dir ? PRECOMP : EMIT;
        end else begin
            case (state_r)
                PRECOMP: begin
                    win_r <= fwd_win_s;
                    pos_r <= pos_r + 4'd1;
                    if (pos_r == P_M1) state_r <= EMIT;
                end
                EMIT: begin
                    if (!rk_valid) begin
                        rk_valid  <= 1'b1;
                        round_key <= cur_key_s;
                        rk_last   <= (round_idx == last_idx_s);
                    end else if (rk_ready) begin
                        if (rk_last) begin
                            state_r  <= IDLE;
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            round_idx <= next_idx_s;
                            round_key <= next_key_s;
                            rk_last   <= (next_idx_s == last_idx_s);
                            if (!held_s) begin
                                win_r <= dir_r ? inv_win_s : fwd_win_s;
                                pos_r <= dir_r ? pos_r - 4'd1 : pos_r + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    rk_valid <= 1'b0;
                    rk_last  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
